onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
Two-master arbiter in front of the single-port 32000x32 on-chip RAM. Port 0 serves the Nios data master; port 1 serves the sensor-sample logger DMA.
- Arbitration is round-robin, with an optional bounded lock for logger bursts.
- Each master sees an Avalon-MM pipelined slave (waitrequest and readdatavalid).
- The RAM port is driven directly and has a fixed read latency of 1 (registered address, unregistered q).

Parameters:
ADDR_W, 15, word address width on all ports
DEPTH, 32000, number of valid words; addresses >= DEPTH are out of range
LOCK_MAX, 8, maximum consecutive port-1 transfers under m1_lock (1..255)

Ports:
clk  in  1  system clock; sole clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  port 0 word address
m0_read  in  1  port 0 read request
m0_write  in  1  port 0 write request
m0_byteenable  in  4  port 0 byte lanes
m0_writedata  in  32  port 0 write data
m0_waitrequest  out  1  port 0 request not accepted this cycle
m0_readdata  out  32  port 0 read data
m0_readdatavalid  out  1  port 0 read data valid
m1_*  same set as m0_*, for port 1
m1_lock  in  1  port 1 requests grant retention across consecutive transfers
mem_address  out  ADDR_W  RAM address
mem_byteenable  out  4  RAM byte enables
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write
mem_writedata  out  32  RAM write data
mem_clken  out  1  RAM clock enable
mem_readdata  in  32  RAM q, valid 1 cycle after address accepted
err_oor  out  1  one-cycle pulse on an out-of-range access

Behaviour:
- Reset (reset_n low, asynchronous):
  - Registered outputs clear: readdatavalid=0, err_oor=0, mem_clken=0.
  - State=ARB, rr_ptr=0 (port 0 favoured), lock_cnt=0.
  - mem_clken goes to 1 on the first clk edge after reset_n deasserts.
- Request: reqN = mN_read | mN_write. Read and write both high on one port is illegal; write wins and the read is ignored.
- Grant is combinational in the current cycle; at most one port is granted per cycle.
  - mN_waitrequest = reqN & ~grantN. It is 0 when the port is idle.
  - Granted port's address, byteenable and writedata pass to mem_*. mem_chipselect = grant & in-range. mem_write = granted write & in-range.
  - No grant: mem_chipselect=0, mem_write=0; other mem_* hold the port 0 values.
- State ARB:
  - Only one port requesting -> that port is granted.
  - Both requesting -> grant port rr_ptr.
  - After each granted transfer, rr_ptr <= other port.
  - Port 1 granted with m1_lock=1 -> go to LOCKED, lock_cnt <= 1.
- State LOCKED:
  - Port 1 is granted whenever req1, regardless of req0; each grant increments lock_cnt.
  - Exit to ARB with rr_ptr <= 0 when m1_lock=0, or when lock_cnt reaches LOCK_MAX after a grant. A port 1 grant while m1_lock=0 also exits.
  - Port 1 idle with m1_lock=1 -> port 0 may be granted that cycle; stay LOCKED and do not increment lock_cnt.
- Read latency: a read granted in cycle N gives mN_readdatavalid=1 in cycle N+1.
  - mN_readdata = mem_readdata for in-range reads, 0 for out-of-range reads.
  - readdatavalid and the responding port id are registered.
  - Back-to-back reads from either or both ports have full throughput: 1 transfer per cycle with no bubbles.
  - Readdata of the non-responding port is don't-care.
- Out-of-range (address >= DEPTH):
  - The transfer is accepted (waitrequest=0) and no RAM access occurs.
  - Writes are dropped; reads return 0 with the usual latency.
  - err_oor pulses high in cycle N+1.
- Reset in mid-operation: a pending readdatavalid is discarded and no stale valid appears after reset.
- Write followed by a read of the same address on the next cycle returns the new data; the RAM handles this, and the arbiter adds no forwarding.

Test Plan:
- Reset, then port 0 writes 0xA5A5_0001 to addr 0x0010 with byteenable 0xF; port 0 reads 0x0010 -> waitrequest=0 both cycles, readdatavalid on the cycle after the read, readdata=0xA5A5_0001.
- Both ports issue continuous reads for 6 cycles, with rr_ptr=0 after reset -> grants alternate 0,1,0,1,0,1; each port's readdatavalid pulses are 1 cycle after its grants; the losing port sees waitrequest=1.
- m1_lock=1 with both ports requesting, LOCK_MAX=8 -> port 1 is granted 8 consecutive cycles, then port 0 is granted next; m0_waitrequest=1 for exactly 8 cycles.
- Write 0xFFFF_FFFF to 0x0020, then write 0x0000_0000 with byteenable 0x2 to 0x0020, then read 0x0020 -> 0xFFFF_00FF.
- Port 1 reads addr 32000 and writes addr 32767 -> no mem_chipselect; read returns 0 with readdatavalid at +1; err_oor pulses once per access; RAM contents are unchanged.
- Assert reset_n low the cycle after a granted read -> readdatavalid=0 immediately and stays 0 after release; the first post-reset grant goes to port 0 when both ports request.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Two-master arbiter in front of a single-port on-chip RAM (1-cycle read
// latency: registered address, unregistered q). Port 0 serves the Nios data
// master, port 1 the sensor-sample logger DMA. Each master sees an Avalon-MM
// pipelined slave. Arbitration is round-robin; port 1 can hold the grant for
// up to LOCK_MAX consecutive transfers by asserting m1_lock.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   m0_* / m1_*            Avalon-MM pipelined slave ports (address, read,
//                          write, byteenable, writedata, waitrequest,
//                          readdata, readdatavalid)
//   m1_lock                port 1 asks to keep the grant across transfers
//   mem_*                  RAM port (address, byteenable, chipselect, write,
//                          writedata, clken, readdata)
//   err_oor                one-cycle pulse, one cycle after an access to an
//                          address >= DEPTH
// -----------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DEPTH    = 32000,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [3:0]        m0_byteenable,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [3:0]        m1_byteenable,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    input  logic              m1_lock,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,

    output logic              err_oor
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [7:0]      LOCK_MAX_C = 8'(LOCK_MAX);
    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);

    state_e     state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;      // port favoured when both request
    logic [7:0] lock_cnt_q, lock_cnt_d;  // port 1 grants in the current lock run

    logic       rvalid_q;   // a read was granted last cycle
    logic       rport_q;    // which port that read belongs to
    logic       roor_q;     // that read was out of range -> return zero
    logic       err_q;
    logic       clken_q;

    logic       req0, req1;
    logic       grant0, grant1;
    logic       any_grant;
    logic       sel_write, sel_read;
    logic       in_range;
    logic [7:0] lock_cnt_inc;

    assign req0         = m0_read | m0_write;
    assign req1         = m1_read | m1_write;
    assign lock_cnt_inc = lock_cnt_q + 8'd1;

    // -------------------------------------------------------------------------
    // Arbitration and next-state
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            ST_ARB: begin
                if (req0 && req1) begin
                    grant0 = ~rr_ptr_q;
                    grant1 = rr_ptr_q;
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end

                if (grant0) rr_ptr_d = 1'b1;
                if (grant1) begin
                    rr_ptr_d = 1'b0;
                    // With LOCK_MAX == 1 the first locked grant already
                    // exhausts the run, so LOCKED is never entered.
                    if (m1_lock && (LOCK_MAX_C > 8'd1)) begin
                        state_d    = ST_LOCKED;
                        lock_cnt_d = 8'd1;
                    end
                end
            end

            ST_LOCKED: begin
                // Port 1 owns the RAM whenever it asks; port 0 only fills
                // cycles where port 1 is idle.
                grant1 = req1;
                grant0 = req0 & ~req1;

                if (grant1) lock_cnt_d = lock_cnt_inc;

                if (!m1_lock || (grant1 && (lock_cnt_inc >= LOCK_MAX_C))) begin
                    state_d    = ST_ARB;
                    rr_ptr_d   = 1'b0;
                    lock_cnt_d = 8'd0;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // RAM port: granted master's request passes straight through; with no
    // grant the port 0 fields are presented but nothing is selected.
    // -------------------------------------------------------------------------
    assign any_grant = grant0 | grant1;

    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;

    // Write wins when read and write are both raised on one port.
    assign sel_write = grant1 ? m1_write : (grant0 & m0_write);
    assign sel_read  = grant1 ? (m1_read & ~m1_write)
                              : (grant0 & m0_read & ~m0_write);

    assign in_range       = {1'b0, mem_address} < DEPTH_C;
    assign mem_chipselect = any_grant & in_range;
    assign mem_write      = sel_write & in_range;
    assign mem_clken      = clken_q;

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    // -------------------------------------------------------------------------
    // State and response registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= 1'b0;
            lock_cnt_q <= 8'd0;
            rvalid_q   <= 1'b0;
            rport_q    <= 1'b0;
            roor_q     <= 1'b0;
            err_q      <= 1'b0;
            clken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= sel_read;
            rport_q    <= grant1;
            roor_q     <= ~in_range;
            err_q      <= any_grant & ~in_range;
            clken_q    <= 1'b1;
        end
    end

    // RAM q arrives one cycle after the address; out-of-range reads never
    // touched the RAM, so their data is forced to zero.
    logic [31:0] rdata;
    assign rdata = roor_q ? 32'h0 : mem_readdata;

    assign m0_readdata      = rdata;
    assign m1_readdata      = rdata;
    assign m0_readdatavalid = rvalid_q & ~rport_q;
    assign m1_readdatavalid = rvalid_q & rport_q;
    assign err_oor          = err_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_onchip_mem_arbiter
//
// Self-checking bench for onchip_mem_arbiter. A behavioural RAM sits on the
// mem_* port. A reference model (grant rules, shadow memory image, expected
// response one cycle later) is evaluated every cycle and compared against the
// DUT; directed sequences exercise the documented scenarios, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

    localparam int ADDR_W   = 15;
    localparam int DEPTH    = 32000;
    localparam int LOCK_MAX = 8;
    localparam int POOL     = 32;   // in-range addresses used by random traffic

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic [31:0]       m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              m1_lock;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              err_oor;

    onchip_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_lock          (m1_lock),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .err_oor          (err_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Behavioural single-port RAM: registered address, unregistered q.
    // -------------------------------------------------------------------------
    logic [31:0]       ram_mem [DEPTH];
    logic [ADDR_W-1:0] ram_addr_q;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect && (int'(mem_address) < DEPTH)) begin
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            ram_addr_q <= mem_address;
        end
    end

    assign mem_readdata = (int'(ram_addr_q) < DEPTH) ? ram_mem[ram_addr_q] : 32'h0;

    // -------------------------------------------------------------------------
    // Bookkeeping and reference model
    // -------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] shadow [DEPTH];     // expected RAM image

    bit          mdl_locked;         // port 1 lock run in progress
    int          mdl_rr;             // port favoured when both request
    int          mdl_run;            // port 1 grants in current lock run
    bit          exp_v0, exp_v1, exp_err;
    logic [31:0] exp_rd;

    // Observations of the DUT used by the directed scenarios.
    int          n_wait0, n_gnt1, n_err;
    bit [7:0]    grant_seq;          // 1 = port 1 got the RAM that cycle
    logic [31:0] last_rd0, last_rd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input bit r0, input bit r1);
        if (mdl_locked) return r1 ? 1 : (r0 ? 0 : -1);
        if (r0 && r1)   return mdl_rr;
        if (r0)         return 0;
        if (r1)         return 1;
        return -1;
    endfunction

    task automatic model_advance(input int g, input bit lock);
        if (!mdl_locked) begin
            if (g >= 0) mdl_rr = 1 - g;
            if (g == 1 && lock) begin
                mdl_run = 1;
                if (mdl_run < LOCK_MAX) mdl_locked = 1'b1;
            end
        end else begin
            if (g == 1) mdl_run++;
            if (!lock || mdl_run >= LOCK_MAX) begin
                mdl_locked = 1'b0;
                mdl_rr     = 0;
                mdl_run    = 0;
            end
        end
    endtask

    task automatic model_reset();
        mdl_locked = 1'b0;
        mdl_rr     = 0;
        mdl_run    = 0;
        exp_v0     = 1'b0;
        exp_v1     = 1'b0;
        exp_err    = 1'b0;
        exp_rd     = 32'h0;
    endtask

    // One bus cycle: called at posedge+1 with inputs already driven. Checks
    // combinational and registered outputs at the negedge, then advances the
    // model on the posedge.
    task automatic step();
        bit                r0, r1, wr, rd, inr;
        int                g;
        logic [ADDR_W-1:0] a;
        logic [3:0]        be;
        logic [31:0]       wd;

        @(negedge clk);
        r0  = m0_read || m0_write;
        r1  = m1_read || m1_write;
        g   = model_grant(r0, r1);
        a   = (g == 1) ? m1_address    : m0_address;
        be  = (g == 1) ? m1_byteenable : m0_byteenable;
        wd  = (g == 1) ? m1_writedata  : m0_writedata;
        inr = int'(a) < DEPTH;
        wr  = (g == 0 && m0_write) || (g == 1 && m1_write);
        rd  = !wr && ((g == 0 && m0_read) || (g == 1 && m1_read));

        check("wait0", m0_waitrequest, r0 && g != 0);
        check("wait1", m1_waitrequest, r1 && g != 1);
        check("mem_cs", mem_chipselect, g >= 0 && inr);
        check("mem_we", mem_write, wr && inr);
        if (g >= 0 && inr) check("mem_addr", mem_address, a);
        if (wr && inr) begin
            check("mem_be", mem_byteenable, be);
            check("mem_wdata", mem_writedata, wd);
        end
        check("rdv0", m0_readdatavalid, exp_v0);
        check("rdv1", m1_readdatavalid, exp_v1);
        if (exp_v0) check("rdata0", m0_readdata, exp_rd);
        if (exp_v1) check("rdata1", m1_readdata, exp_rd);
        check("err_oor", err_oor, exp_err);

        if (m0_waitrequest) n_wait0++;
        if (r1 && !m1_waitrequest) n_gnt1++;
        if (err_oor) n_err++;
        grant_seq = {grant_seq[6:0], r1 && !m1_waitrequest};
        if (m0_readdatavalid) last_rd0 = m0_readdata;
        if (m1_readdatavalid) last_rd1 = m1_readdata;

        @(posedge clk);
        if (wr && inr)
            for (int b = 0; b < 4; b++)
                if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
        exp_v0  = rd && g == 0;
        exp_v1  = rd && g == 1;
        exp_rd  = (rd && inr) ? shadow[a] : 32'h0;
        exp_err = g >= 0 && !inr;
        model_advance(g, m1_lock);
        #1;
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr, input int addr,
                            input logic [3:0] be, input logic [31:0] wd);
        if (p == 0) begin
            m0_read = rd; m0_write = wr; m0_address = ADDR_W'(addr);
            m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = ADDR_W'(addr);
            m1_byteenable = be; m1_writedata = wd;
        end
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        m1_lock = 1'b0;
    endtask

    // Hold reset for two cycles, check reset values, release at a negedge and
    // return at posedge+1 with the RAM clock enable up.
    task automatic do_reset();
        reset_n = 1'b0;
        idle_all();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_rdv0", m0_readdatavalid, 1'b0);
        check("rst_rdv1", m1_readdatavalid, 1'b0);
        check("rst_err", err_oor, 1'b0);
        check("rst_clken", mem_clken, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("clken_up", mem_clken, 1'b1);
        check("post_rst_rdv0", m0_readdatavalid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        int          nbad;

        reset_n   = 1'b0;
        idle_all();
        grant_seq = '0;
        last_rd0  = 32'h0;
        last_rd1  = 32'h0;

        // Basic write then read on port 0.
        do_reset();
        set_port(0, 1'b0, 1'b1, 'h10, 4'hF, 32'hA5A5_0001); step();
        set_port(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);         step();
        idle_all();                                          step();
        check("t1_readback", last_rd0, 32'hA5A5_0001);

        // Round-robin alternation with both ports reading continuously.
        do_reset();
        set_port(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        grant_seq = '0;
        repeat (6) step();
        check("rr_sequence", 32'(grant_seq[5:0]), 32'b010101);
        idle_all(); step();

        // Lock run: port 1 keeps the RAM for LOCK_MAX transfers.
        do_reset();
        set_port(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        m1_lock = 1'b1;
        n_wait0 = 0;
        n_gnt1  = 0;
        repeat (10) step();
        check("lock_wait0_cycles", n_wait0, LOCK_MAX);
        check("lock_port1_grants", n_gnt1, LOCK_MAX);
        check("lock_release_to_p0", 32'(grant_seq[0]), 32'd0);
        idle_all(); step();

        // Byte-enable merge.
        set_port(0, 1'b0, 1'b1, 'h20, 4'hF, 32'hFFFF_FFFF); step();
        set_port(0, 1'b0, 1'b1, 'h20, 4'h2, 32'h0000_0000); step();
        set_port(0, 1'b1, 1'b0, 'h20, 4'hF, 32'h0);         step();
        idle_all();                                          step();
        check("byteenable_merge", last_rd0, 32'hFFFF_00FF);

        // Out-of-range accesses on port 1.
        n_err    = 0;
        last_rd1 = 32'hDEAD_BEEF;
        set_port(1, 1'b1, 1'b0, 32000, 4'hF, 32'h0);         step();
        set_port(1, 1'b0, 1'b1, 32767, 4'hF, 32'h1234_5678); step();
        idle_all();                                           step(); step();
        check("oor_err_pulses", n_err, 2);
        check("oor_read_zero", last_rd1, 32'h0);

        // Reset right after a granted read discards the pending response.
        set_port(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0); step();
        reset_n = 1'b0;
        #1;
        check("midrst_rdv0", m0_readdatavalid, 1'b0);
        check("midrst_rdv1", m1_readdatavalid, 1'b0);
        do_reset();
        set_port(0, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        set_port(1, 1'b1, 1'b0, 'h10, 4'hF, 32'h0);
        step();
        check("midrst_first_grant_p0", 32'(grant_seq[0]), 32'd0);
        idle_all(); step();

        // Fill the address pool so every random read has a known value.
        for (int a = 0; a < POOL; a++) begin
            set_port(0, 1'b0, 1'b1, a, 4'hF, $urandom());
            step();
        end
        idle_all(); step();

        // Randomized traffic on both ports, with lock runs.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                int op, addr;
                op   = $urandom_range(0, 19);
                addr = ($urandom_range(0, 15) == 0) ? 32000 + $urandom_range(0, 767)
                                                    : $urandom_range(0, POOL - 1);
                rnd  = $urandom();
                set_port(p, (op >= 5 && op < 12) || op >= 18, op >= 12,
                         addr, 4'($urandom_range(0, 15)), rnd);
            end
            if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
            step();
        end
        idle_all(); step(); step();

        nbad = 0;
        for (int a = 0; a < POOL; a++)
            if (ram_mem[a] !== shadow[a]) nbad++;
        check("ram_image", nbad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
